// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcode/funct constants and control word for the multicycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_LW_WB    = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10
  } state_e;

  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;

  localparam logic [5:0] OP0_NOP = 6'h00;
  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  typedef struct packed {
    logic       pc_en;
    logic       pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational state/opcode/funct to control word decode; MC_ADDI_EN adds ADDI states
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.alu_op    = ALU_ADD;
    ctrl_o.alu_src_b = SRCB_RT;
    case (state_i)
      S_FETCH: begin
        ctrl_o.pc_en     = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_S2;
        case (opcode_i)
          OP_OTHER0, OP_LW, OP_SW, OP_BEQ: ctrl_o.illegal = 1'b0;
`ifdef MC_ADDI_EN
          OP_ADDI:                         ctrl_o.illegal = 1'b0;
`endif
          default:                         ctrl_o.illegal = 1'b1;
        endcase
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        case (funct_i)
          OP0_NOP, OP0_ADD: ctrl_o.alu_op  = ALU_ADD;
          OP0_SUB:          ctrl_o.alu_op  = ALU_SUB;
          OP0_AND:          ctrl_o.alu_op  = ALU_AND;
          OP0_OR:           ctrl_o.alu_op  = ALU_OR;
          OP0_SLT:          ctrl_o.alu_op  = ALU_SLT;
          default:          ctrl_o.illegal = 1'b1;
        endcase
      end
      // IR is not rewritten until the next fetch, so funct still identifies a nop here
      S_R_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = (funct_i != OP0_NOP);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.i_or_d   = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      S_LW_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_source = 1'b1;
        ctrl_o.pc_en     = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
`endif
      default: ctrl_o.illegal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM and retired counter; MC_ADDI_EN enables ADDI
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 pc_source,
  output logic                 ir_write,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [3:0]           state
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 retire;
  logic                 run;
  ctrl_t                cw;

  mips_ctrl_outdec u_outdec (
    .state_i  (state_q),
    .opcode_i (opcode),
    .funct_i  (funct),
    .ctrl_o   (cw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_OTHER0:    state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = S_EXEC_I;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = cw.illegal ? S_FETCH : S_R_WB;
      S_R_WB:     retire  = 1'b1;
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_LW_WB : S_MEM_RD;
      S_LW_WB:    retire  = 1'b1;
      S_MEM_WR: begin
        state_d = mem_ready ? S_FETCH : S_MEM_WR;
        retire  = mem_ready;
      end
      S_BRANCH:   retire  = 1'b1;
`ifdef MC_ADDI_EN
      S_EXEC_I:   state_d = S_I_WB;
      S_I_WB:     retire  = 1'b1;
`endif
      default:    state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_WIDTH'(retire);
  end

  // Strobes are held off while reset is high so nothing is written during recovery
  assign run        = ~reset;
  assign pc_en      = run & cw.pc_en & ((state_q == S_FETCH) ? mem_ready : zero);
  assign ir_write   = run & cw.ir_write & mem_ready;
  assign mem_read   = run & cw.mem_read;
  assign mem_write  = run & cw.mem_write;
  assign reg_write  = run & cw.reg_write;
  assign illegal    = run & cw.illegal;
  assign pc_source  = cw.pc_source;
  assign i_or_d     = cw.i_or_d;
  assign mem_to_reg = cw.mem_to_reg;
  assign reg_dst    = cw.reg_dst;
  assign alu_src_a  = cw.alu_src_a;
  assign alu_src_b  = cw.alu_src_b;
  assign alu_op     = cw.alu_op;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic        pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [31:0] retired;
  logic [3:0]  state;

  logic        pc_en_w, pc_source_w, ir_write_w, i_or_d_w, mem_read_w, mem_write_w;
  logic        mem_to_reg_w, reg_dst_w, reg_write_w, alu_src_a_w, illegal_w;
  logic [1:0]  alu_src_b_w;
  logic [2:0]  alu_op_w;
  logic [1:0]  retired_w;
  logic [3:0]  state_w;

  mips_multicycle_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_source(pc_source), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .retired(retired), .state(state)
  );

  // Narrow counter instance exercises wrap-around with few retirements
  mips_multicycle_ctrl #(.CNT_WIDTH(2)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en_w), .pc_source(pc_source_w), .ir_write(ir_write_w),
    .i_or_d(i_or_d_w), .mem_read(mem_read_w), .mem_write(mem_write_w), .mem_to_reg(mem_to_reg_w),
    .reg_dst(reg_dst_w), .reg_write(reg_write_w), .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w),
    .alu_op(alu_op_w), .illegal(illegal_w), .retired(retired_w), .state(state_w)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] PCEN = 16'h8000, PCS = 16'h4000, IRW = 16'h2000, IOD = 16'h1000;
  localparam logic [15:0] MRD  = 16'h0800, MWR = 16'h0400, M2R = 16'h0200, RDST = 16'h0100;
  localparam logic [15:0] RW   = 16'h0080, SA  = 16'h0040, ILL = 16'h0001;

  function automatic logic [15:0] sb(input logic [1:0] x);
    return {10'd0, x, 4'd0};
  endfunction

  function automatic logic [15:0] aop(input logic [2:0] x);
    return {12'd0, x, 1'b0};
  endfunction

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [15:0] cw;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   r       = 0;

  logic [15:0] act_cw;
  assign act_cw = {pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".state"}, 32'(state), 32'(e.st));
      chk({e.name, ".ctrl"}, 32'(act_cw), 32'(e.cw));
      chk({e.name, ".retired"}, retired, e.ret);
      chk({e.name, ".retired_w"}, 32'(retired_w), 32'(e.ret[1:0]));
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [3:0] est, input logic [15:0] ecw,
                     input logic [31:0] eret);
    exp_t e;
    reset = rst; opcode = op; funct = fn; zero = z; mem_ready = mr;
    e.name = nm; e.st = est; e.cw = ecw; e.ret = eret;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] F1 = PCEN | IRW | MRD | 16'h0010;

  initial begin
    @(posedge clk); #1;
    cyc("reset", 1, 6'h00, 6'h20, 0, 1, S_FETCH, sb(2'b01), 0);

    cyc("add_f",  0, 6'h00, 6'h20, 0, 1, S_FETCH,  F1, r);
    cyc("add_d",  0, 6'h00, 6'h20, 0, 1, S_DECODE, sb(2'b11), r);
    cyc("add_x",  0, 6'h00, 6'h20, 0, 1, S_EXEC_R, SA | aop(3'd0), r);
    cyc("add_wb", 0, 6'h00, 6'h20, 0, 1, S_R_WB,   RDST | RW, r);
    r++;

    cyc("fetch_wait", 0, 6'h23, 6'h00, 0, 0, S_FETCH, MRD | sb(2'b01), r);
    cyc("lw_f",  0, 6'h23, 6'h00, 0, 1, S_FETCH,    F1, r);
    cyc("lw_d",  0, 6'h23, 6'h00, 0, 1, S_DECODE,   sb(2'b11), r);
    cyc("lw_a",  0, 6'h23, 6'h00, 0, 1, S_MEM_ADDR, SA | sb(2'b10), r);
    for (int i = 0; i < 3; i++)
      cyc("lw_rd_wait", 0, 6'h23, 6'h00, 0, 0, S_MEM_RD, IOD | MRD, r);
    cyc("lw_rd", 0, 6'h23, 6'h00, 0, 1, S_MEM_RD, IOD | MRD, r);
    cyc("lw_wb", 0, 6'h23, 6'h00, 0, 1, S_LW_WB,  M2R | RW, r);
    r++;

    cyc("beq1_f", 0, 6'h04, 6'h00, 1, 1, S_FETCH,  F1, r);
    cyc("beq1_d", 0, 6'h04, 6'h00, 1, 1, S_DECODE, sb(2'b11), r);
    cyc("beq1_b", 0, 6'h04, 6'h00, 1, 1, S_BRANCH, SA | aop(3'd1) | PCS | PCEN, r);
    r++;
    cyc("beq0_f", 0, 6'h04, 6'h00, 0, 1, S_FETCH,  F1, r);
    cyc("beq0_d", 0, 6'h04, 6'h00, 0, 1, S_DECODE, sb(2'b11), r);
    cyc("beq0_b", 0, 6'h04, 6'h00, 0, 1, S_BRANCH, SA | aop(3'd1) | PCS, r);
    r++;

    cyc("illop_f", 0, 6'h3F, 6'h20, 0, 1, S_FETCH,  F1, r);
    cyc("illop_d", 0, 6'h3F, 6'h20, 0, 1, S_DECODE, sb(2'b11) | ILL, r);
    cyc("illfn_f", 0, 6'h00, 6'h01, 0, 1, S_FETCH,  F1, r);
    cyc("illfn_d", 0, 6'h00, 6'h01, 0, 1, S_DECODE, sb(2'b11), r);
    cyc("illfn_x", 0, 6'h00, 6'h01, 0, 1, S_EXEC_R, SA | ILL, r);

    cyc("nop_f",  0, 6'h00, 6'h00, 0, 1, S_FETCH,  F1, r);
    cyc("nop_d",  0, 6'h00, 6'h00, 0, 1, S_DECODE, sb(2'b11), r);
    cyc("nop_x",  0, 6'h00, 6'h00, 0, 1, S_EXEC_R, SA, r);
    cyc("nop_wb", 0, 6'h00, 6'h00, 0, 1, S_R_WB,   RDST, r);
    r++;

    cyc("sub_f",  0, 6'h00, 6'h22, 0, 1, S_FETCH,  F1, r);
    cyc("sub_d",  0, 6'h00, 6'h22, 0, 1, S_DECODE, sb(2'b11), r);
    cyc("sub_x",  0, 6'h00, 6'h22, 0, 1, S_EXEC_R, SA | aop(3'd1), r);
    cyc("sub_wb", 0, 6'h00, 6'h22, 0, 1, S_R_WB,   RDST | RW, r);
    r++;

    cyc("or_f",  0, 6'h00, 6'h25, 0, 1, S_FETCH,  F1, r);
    cyc("or_d",  0, 6'h00, 6'h25, 0, 1, S_DECODE, sb(2'b11), r);
    cyc("or_x",  0, 6'h00, 6'h25, 0, 1, S_EXEC_R, SA | aop(3'd3), r);
    cyc("or_wb", 0, 6'h00, 6'h25, 0, 1, S_R_WB,   RDST | RW, r);
    r++;

    cyc("addi_f", 0, 6'h08, 6'h00, 0, 1, S_FETCH, F1, r);
`ifdef MC_ADDI_EN
    cyc("addi_d",  0, 6'h08, 6'h00, 0, 1, S_DECODE, sb(2'b11), r);
    cyc("addi_x",  0, 6'h08, 6'h00, 0, 1, S_EXEC_I, SA | sb(2'b10), r);
    cyc("addi_wb", 0, 6'h08, 6'h00, 0, 1, S_I_WB,   RW, r);
    r++;
`else
    cyc("addi_d", 0, 6'h08, 6'h00, 0, 1, S_DECODE, sb(2'b11) | ILL, r);
`endif

    cyc("sw_f",      0, 6'h2B, 6'h00, 0, 1, S_FETCH,    F1, r);
    cyc("sw_d",      0, 6'h2B, 6'h00, 0, 1, S_DECODE,   sb(2'b11), r);
    cyc("sw_a",      0, 6'h2B, 6'h00, 0, 1, S_MEM_ADDR, SA | sb(2'b10), r);
    cyc("sw_wait",   0, 6'h2B, 6'h00, 0, 0, S_MEM_WR,   IOD | MWR, r);
    cyc("sw_wr",     0, 6'h2B, 6'h00, 0, 1, S_MEM_WR,   IOD | MWR, r);
    r++;

    cyc("swr_f",     0, 6'h2B, 6'h00, 0, 1, S_FETCH,    F1, r);
    cyc("swr_d",     0, 6'h2B, 6'h00, 0, 1, S_DECODE,   sb(2'b11), r);
    cyc("swr_a",     0, 6'h2B, 6'h00, 0, 1, S_MEM_ADDR, SA | sb(2'b10), r);
    cyc("swr_wr",    0, 6'h2B, 6'h00, 0, 0, S_MEM_WR,   IOD | MWR, r);
    cyc("swr_rst",   1, 6'h2B, 6'h00, 0, 0, S_MEM_WR,   IOD, r);
    r = 0;
    cyc("post_rst",  0, 6'h00, 6'h24, 0, 1, S_FETCH,    F1, r);
    cyc("and_d",     0, 6'h00, 6'h24, 0, 1, S_DECODE,   sb(2'b11), r);
    cyc("and_x",     0, 6'h00, 6'h24, 0, 1, S_EXEC_R,   SA | aop(3'd2), r);
    cyc("and_wb",    0, 6'h00, 6'h24, 0, 1, S_R_WB,     RDST | RW, r);
    r++;
    cyc("final_f",   0, 6'h00, 6'h2A, 0, 0, S_FETCH,    MRD | sb(2'b01), r);

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
